// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// result-source encodings and memory-wait FSM states.
package hazard_pkg;

  // Operand source select for the E-stage ALU inputs
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // ResultSrc encodings carried down the pipeline
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Memory-wait FSM states
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding compare: picks the youngest in-flight producer
// of the E-stage source register, M stage first, then W.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd
);

  fwd_sel_t sel;

  // M beats W because it holds the more recent write to the same register; x0 never forwards
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      sel = FWD_WB;
    end
  end

  assign fwd = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch
// flush and a memory-wait FSM with watchdog for multicycle data memory.
// Optional build macro HAZARD_PERF_EN adds stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        ResultSrcM,
  input  logic              MemWriteM,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       PerfStallCnt,
  output logic [31:0]       PerfFlushCnt,
`endif
  output logic              MemErr
);

  // Last counter value before the watchdog gives up on the access
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  hz_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_err_q, mem_err_d;

  logic [REG_AW-1:0] rs_e [2];
  logic [1:0]        fwd  [2];
  logic              lw_stall;
  logic              mem_acc;
  logic              mem_stall;

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
        .rs_e        (rs_e[gi]),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd[gi])
      );
    end
  endgenerate

  assign lw_stall = (ResultSrcE == RES_MEM) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_acc  = MemWriteM || (ResultSrcM == RES_MEM);

  // Memory-wait FSM next state, watchdog counter and sticky error
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    mem_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_acc && !MemReadyM) begin
          state_d   = MEM_WAIT;
          cnt_d     = 8'd1;
          mem_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Stall holds even on the completing cycle: data lands on the next edge
        mem_stall = 1'b1;
        if (MemReadyM) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RUN;
          cnt_d     = 8'd0;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Stall/flush/forward outputs; memory stall outranks branch flush, which outranks load-use
  always_comb begin
    ForwardAE = fwd[0];
    ForwardBE = fwd[1];
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (!rst_n) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
    end else if (mem_stall) begin
      // A branch resolved now stays in the held E stage and flushes once released
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else begin
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall && !PCSrcE;
      FlushE = lw_stall || PCSrcE;
      FlushD = PCSrcE;
    end
  end

  // FSM state, watchdog counter and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Event counters: StallF cycles and branch-caused E flushes, free-running wrap
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (StallF) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (!mem_stall && PCSrcE) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign PerfStallCnt = perf_stall_q;
  assign PerfFlushCnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: table of combinational vectors plus
// hand-written sequences for memory wait, watchdog and reset corner cases.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE, ResultSrcM;
  logic       MemWriteM, RegWriteM, RegWriteW, PCSrcE, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStallCnt, PerfFlushCnt;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .ResultSrcE (ResultSrcE),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .MemReadyM  (MemReadyM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
`ifdef HAZARD_PERF_EN
    .PerfStallCnt (PerfStallCnt),
    .PerfFlushCnt (PerfFlushCnt),
`endif
    .MemErr     (MemErr)
  );

  // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE}
  logic [9:0] outs;
  assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE};

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rse, rsm;
    logic       mw, rwm, rww, pcs, rdy;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string name, logic [4:0] rs1d, logic [4:0] rs2d,
                              logic [4:0] rs1e, logic [4:0] rs2e, logic [4:0] rde,
                              logic [4:0] rdm, logic [4:0] rdw, logic [1:0] rse,
                              logic [1:0] rsm, logic mw, logic rwm, logic rww,
                              logic pcs, logic rdy, logic [9:0] exp);
    vec_t v;
    v.name = name; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rse = rse; v.rsm = rsm;
    v.mw = mw; v.rwm = rwm; v.rww = rww; v.pcs = pcs; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; ResultSrcM = 2'b00;
    MemWriteM = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0; MemReadyM = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                  name           rs1d rs2d rs1e rs2e rde rdm rdw rse    rsm    mw rwm rww pcs rdy exp
    vecs[0]  = mk("fwd_m_prio",    0, 0, 5, 0, 0, 5, 5, 2'b00, 2'b00, 0, 1, 1, 0, 1, 10'b10_00_0000_00);
    vecs[1]  = mk("fwd_w_only",    0, 0, 5, 0, 0, 5, 5, 2'b00, 2'b00, 0, 0, 1, 0, 1, 10'b01_00_0000_00);
    vecs[2]  = mk("fwd_x0",        0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 1, 10'b00_00_0000_00);
    vecs[3]  = mk("fwd_a_m_b_w",   0, 0, 3, 9, 0, 3, 9, 2'b00, 2'b00, 0, 1, 1, 0, 1, 10'b10_01_0000_00);
    vecs[4]  = mk("loaduse",       0, 7, 0, 0, 7, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 10'b00_00_1100_01);
    vecs[5]  = mk("loaduse_after", 0, 7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 10'b00_00_0000_00);
    vecs[6]  = mk("loaduse_rd0",   0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 10'b00_00_0000_00);
    vecs[7]  = mk("alu_no_stall",  7, 0, 0, 0, 7, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 10'b00_00_0000_00);
    vecs[8]  = mk("branch_lu",     7, 0, 0, 0, 7, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 1, 10'b00_00_0000_11);
    vecs[9]  = mk("load_ready",    0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 1, 10'b00_00_0000_00);
    vecs[10] = mk("store_ready",   0, 0, 0, 4, 0, 4, 0, 2'b00, 2'b00, 1, 1, 0, 0, 1, 10'b00_10_0000_00);

    // Reset: forward inputs active but outputs must be gated
    clear_inputs();
    rst_n = 1'b0;
    RdM = 5'd5; Rs1E = 5'd5; RegWriteM = 1'b1;
    tick();
    @(negedge clk);
    check("reset_outs", 32'(outs), 32'(10'b00_00_0000_11));
    check("reset_memerr", 32'(MemErr), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_inputs();

    // Table-driven combinational vectors, all in RUN
    for (int i = 0; i < 11; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      ResultSrcE = vecs[i].rse; ResultSrcM = vecs[i].rsm;
      MemWriteM = vecs[i].mw; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      PCSrcE = vecs[i].pcs; MemReadyM = vecs[i].rdy;
      @(negedge clk);
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      tick();
    end
    clear_inputs();

    // Memory wait: 3 not-ready cycles, ready on the 4th; branch in E deferred until release
    for (int c = 0; c < 5; c++) begin
      ResultSrcM = (c < 4) ? 2'b01 : 2'b00;
      MemReadyM  = (c == 3);
      PCSrcE     = 1'b1;
      @(negedge clk);
      if (c < 4) check($sformatf("memwait_c%0d", c), 32'(outs[5:0]), 32'(6'b1111_00));
      else       check("memwait_release", 32'(outs[5:0]), 32'(6'b0000_11));
      tick();
    end
    clear_inputs();
    check("memwait_no_err", 32'(MemErr), 32'd0);

    // Watchdog: store never completes, 16 stalled cycles then abort
    MemWriteM = 1'b1;
    MemReadyM = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("wdog_c%0d", c), 32'({outs[5:0], MemErr}), 32'(7'b1111_00_0));
      tick();
    end
    MemWriteM = 1'b0;
    @(negedge clk);
    check("wdog_release", 32'({outs[5:0], MemErr}), 32'(7'b0000_00_1));
    tick();
    tick();
    @(negedge clk);
    check("wdog_sticky", 32'(MemErr), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("wdog_reset_clear", 32'(MemErr), 32'd0);
    tick();

    // Reset while in MEM_WAIT returns to RUN
    ResultSrcM = 2'b01;
    MemReadyM  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("midwait_stalled", 32'(outs[5:0]), 32'(6'b1111_00));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ResultSrcM = 2'b00;
    MemReadyM  = 1'b1;
    @(negedge clk);
    check("midwait_run", 32'({outs[5:0], MemErr}), 32'(7'b0000_00_0));
`ifdef HAZARD_PERF_EN
    check("midwait_perf_stall", PerfStallCnt, 32'd0);
    check("midwait_perf_flush", PerfFlushCnt, 32'd0);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
